// File: rtl/osd_tile_ctrl.sv
// OSD tile-map controller: decodes SPI slave writes into tile-map writes and
// control registers, and runs CLEAR / SCROLL engines on the tile-map RAM.
module osd_tile_ctrl #(
  parameter int unsigned c_chars_x = 64,
  parameter int unsigned c_chars_y = 24,
  parameter int unsigned c_init_on = 1,
  parameter int unsigned c_inverse = 1,
  parameter int unsigned c_tm_bits = 11
) (
  input  logic                     clk_pixel,
  input  logic                     rstn,
  input  logic                     i_wr,
  input  logic [31:0]              i_addr,
  input  logic [7:0]               i_data,
  output logic                     o_tm_we,
  output logic [c_tm_bits-1:0]     o_tm_addr,
  output logic [8+c_inverse-1:0]   o_tm_wdata,
  output logic                     o_tm_re,
  output logic [c_tm_bits-1:0]     o_tm_raddr,
  input  logic [8+c_inverse-1:0]   i_tm_rdata,
  output logic                     o_osd_en,
  output logic                     o_busy
);

  localparam int unsigned N = c_chars_x * c_chars_y;
  localparam int unsigned W = 8 + c_inverse;
  localparam logic [c_tm_bits-1:0] LAST    = c_tm_bits'(N - 1);
  localparam logic [c_tm_bits-1:0] LAST_SC = c_tm_bits'(N - c_chars_x - 1);
  localparam logic [c_tm_bits-1:0] CX      = c_tm_bits'(c_chars_x);
  localparam logic [c_tm_bits-1:0] CX_P1   = c_tm_bits'(c_chars_x + 1);
  localparam bit HAS_ROWS = (c_chars_y > 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, SC_RD, SC_CAP, SC_WR, SC_FILL
  } state_t;

  state_t               state;
  logic [c_tm_bits-1:0] idx;
  logic [W-1:0]         cap;
  logic [7:0]           fill_char;

  logic         tile_wr;
  logic         reg_wr;
  logic         cmd_wr;
  logic [W-1:0] spi_word;
  logic [W-1:0] fill_word;
  logic         addr_unused;

  assign tile_wr     = i_wr && (i_addr[31:24] == 8'hFD);
  assign reg_wr      = i_wr && (i_addr[31:24] == 8'hFE);
  assign cmd_wr      = reg_wr && (i_addr[1:0] == 2'd2);
  // With c_inverse=0 the cast drops the inverse bit and keeps only i_data.
  assign spi_word    = W'({i_addr[16], i_data});
  assign fill_word   = W'(fill_char);
  assign addr_unused = ^i_addr;

  always_ff @(posedge clk_pixel or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      idx        <= '0;
      cap        <= '0;
      fill_char  <= 8'h20;
      o_osd_en   <= (c_init_on != 0);
      o_tm_we    <= 1'b0;
      o_tm_addr  <= '0;
      o_tm_wdata <= '0;
      o_tm_re    <= 1'b0;
      o_tm_raddr <= '0;
      o_busy     <= 1'b0;
    end else begin
      o_tm_we <= 1'b0;
      o_tm_re <= 1'b0;

      if (reg_wr) begin
        case (i_addr[1:0])
          2'd0:    o_osd_en  <= i_data[0];
          2'd1:    fill_char <= i_data;
          default: ;
        endcase
      end

      // SPI tile writes own the write port; engine states below hold when it fires.
      if (tile_wr) begin
        o_tm_we    <= 1'b1;
        o_tm_addr  <= i_addr[c_tm_bits-1:0];
        o_tm_wdata <= spi_word;
      end

      case (state)
        IDLE: begin
          if (cmd_wr && i_data == 8'h01) begin
            state  <= CLEAR;
            idx    <= '0;
            o_busy <= 1'b1;
          end else if (cmd_wr && i_data == 8'h02) begin
            idx    <= '0;
            o_busy <= 1'b1;
            if (HAS_ROWS) begin
              state      <= SC_RD;
              o_tm_re    <= 1'b1;
              o_tm_raddr <= CX;
            end else begin
              state <= SC_FILL;
            end
          end
        end

        CLEAR, SC_FILL: begin
          if (!tile_wr) begin
            o_tm_we    <= 1'b1;
            o_tm_addr  <= idx;
            o_tm_wdata <= fill_word;
            if (idx == LAST) begin
              state  <= IDLE;
              idx    <= '0;
              o_busy <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        // Read strobe is issued on entry to SC_RD so the RAM data lands in SC_CAP.
        SC_RD: state <= SC_CAP;

        SC_CAP: begin
          cap   <= i_tm_rdata;
          state <= SC_WR;
        end

        SC_WR: begin
          if (!tile_wr) begin
            o_tm_we    <= 1'b1;
            o_tm_addr  <= idx;
            o_tm_wdata <= cap;
            idx        <= idx + 1'b1;
            if (idx == LAST_SC) begin
              state <= SC_FILL;
            end else begin
              state      <= SC_RD;
              o_tm_re    <= 1'b1;
              o_tm_raddr <= idx + CX_P1;
            end
          end
        end

        default: begin
          state  <= IDLE;
          idx    <= '0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
